// File: rtl/reg_bus_arbiter_if.sv
// reg_bus_arbiter_if: request/transfer bundle between requesters and the register-bus arbiter.
//   req       : per-requester transfer request
//   src, dst  : per-requester source/destination register index, IW bits per slice
//   ack, err  : one-cycle completion pulse to the granted requester, err marks a rejected request
//   reg_read  : per-register bus-drive enable
//   reg_write : per-register write strobe
//   busy      : arbiter is mid-transfer
// Modports: master (requester side) and slave (arbiter side).
interface reg_bus_arbiter_if #(
    parameter int unsigned NREG = 4,
    parameter int unsigned NREQ = 2
);
    localparam int unsigned IW = (NREG > 1) ? $clog2(NREG) : 1;

    logic [NREQ-1:0]    req;
    logic [NREQ*IW-1:0] src;
    logic [NREQ*IW-1:0] dst;
    logic [NREQ-1:0]    ack;
    logic               err;
    logic [NREG-1:0]    reg_read;
    logic [NREG-1:0]    reg_write;
    logic               busy;

    modport master (
        output req, src, dst,
        input  ack, err, reg_read, reg_write, busy
    );

    modport slave (
        input  req, src, dst,
        output ack, err, reg_read, reg_write, busy
    );
endinterface

// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter: arbitrates register-to-register copies over a shared data bus.
// A granted transfer runs DRIVE (source drives bus), STROBE (destination write strobe) and
// RELEASE (source still driving, ack). Invalid requests (src==dst or index out of range) take a
// single REJECT cycle that acks with err. All outputs decode from state/latched flops only.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : reg_bus_arbiter_if.slave (req/src/dst in; ack/err/reg_read/reg_write/busy out)
// Build option: define REG_BUS_RR_EN for round-robin arbitration; otherwise fixed priority with
// requester 0 highest.
module reg_bus_arbiter #(
    parameter int unsigned NREG = 4,
    parameter int unsigned NREQ = 2
) (
    input logic              clk,
    input logic              rst,
    reg_bus_arbiter_if.slave bus
);
    localparam int unsigned IW  = (NREG > 1) ? $clog2(NREG) : 1;
    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StDrive,
        StStrobe,
        StRelease,
        StReject
    } state_e;

    state_e         state_q, state_d;
    logic [IDW-1:0] id_q;
    logic [IW-1:0]  src_q;
    logic [IW-1:0]  dst_q;

    logic           found;
    logic           grant;
    logic           bad;
    logic [IDW-1:0] win;
    logic [IW-1:0]  win_src;
    logic [IW-1:0]  win_dst;

`ifdef REG_BUS_RR_EN
    // Index where the next search begins (one past the last winner).
    logic [IDW-1:0] ptr_q;
    int unsigned    rr_idx;
`endif

    // Winner selection and validity check of the winner's indices.
    always_comb begin
        found   = 1'b0;
        win     = '0;
        win_src = '0;
        win_dst = '0;
`ifdef REG_BUS_RR_EN
        rr_idx  = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            rr_idx = (32'(ptr_q) + k) % NREQ;
            if (!found && bus.req[rr_idx]) begin
                found = 1'b1;
                win   = IDW'(rr_idx);
            end
        end
`else
        // Descending scan so the lowest requesting index wins.
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                found = 1'b1;
                win   = IDW'(i);
            end
        end
`endif
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win == IDW'(i)) begin
                win_src = bus.src[i*IW +: IW];
                win_dst = bus.dst[i*IW +: IW];
            end
        end
        bad = (win_src == win_dst) || (32'(win_src) >= NREG) || (32'(win_dst) >= NREG);
    end

    // State register and transfer latches; inputs are captured only on a grant in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            id_q    <= '0;
            src_q   <= '0;
            dst_q   <= '0;
`ifdef REG_BUS_RR_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (grant) begin
                id_q  <= win;
                src_q <= win_src;
                dst_q <= win_dst;
`ifdef REG_BUS_RR_EN
                ptr_q <= (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
`endif
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    grant   = 1'b1;
                    state_d = bad ? StReject : StDrive;
                end
            end
            StDrive:   state_d = StStrobe;
            StStrobe:  state_d = StRelease;
            StRelease: state_d = StIdle;
            StReject:  state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Output decode from flops only.
    always_comb begin
        logic read_en;
        logic write_en;
        logic ack_en;
        read_en       = 1'b0;
        write_en      = 1'b0;
        ack_en        = 1'b0;
        bus.err       = 1'b0;
        bus.busy      = (state_q != StIdle);
        bus.reg_read  = '0;
        bus.reg_write = '0;
        bus.ack       = '0;
        unique case (state_q)
            StDrive:  read_en = 1'b1;
            StStrobe: begin
                read_en  = 1'b1;
                write_en = 1'b1;
            end
            StRelease: begin
                read_en = 1'b1;
                ack_en  = 1'b1;
            end
            StReject: begin
                ack_en  = 1'b1;
                bus.err = 1'b1;
            end
            default: ;
        endcase
        for (int unsigned i = 0; i < NREG; i++) begin
            if (read_en && (src_q == IW'(i))) begin
                bus.reg_read[i] = 1'b1;
            end
            if (write_en && (dst_q == IW'(i))) begin
                bus.reg_write[i] = 1'b1;
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (ack_en && (id_q == IDW'(i))) begin
                bus.ack[i] = 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_reg_bus_arbiter.sv
// tb_reg_bus_arbiter: directed bench for reg_bus_arbiter (NREG=4/NREQ=2 plus NREG=3/NREQ=1).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_reg_bus_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    reg_bus_arbiter_if #(.NREG(4), .NREQ(2)) bus ();
    reg_bus_arbiter #(.NREG(4), .NREQ(2)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    reg_bus_arbiter_if #(.NREG(3), .NREQ(1)) bus3 ();
    reg_bus_arbiter #(.NREG(3), .NREQ(1)) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_rd"},   32'(bus.reg_read),  32'h0);
        check({tag, "_wr"},   32'(bus.reg_write), 32'h0);
        check({tag, "_ack"},  32'(bus.ack),       32'h0);
        check({tag, "_err"},  32'(bus.err),       32'h0);
        check({tag, "_busy"}, 32'(bus.busy),      32'h0);
    endtask

    // Called at a falling edge with req set up in IDLE; returns at the falling edge of the
    // IDLE cycle after RELEASE.
    task automatic xfer(input string tag, input int id, input logic [3:0] rd,
                        input logic [3:0] wr, input bit mutate);
        @(negedge clk);
        check({tag, "_drv_rd"},   32'(bus.reg_read),  32'(rd));
        check({tag, "_drv_wr"},   32'(bus.reg_write), 32'h0);
        check({tag, "_drv_ack"},  32'(bus.ack),       32'h0);
        check({tag, "_drv_busy"}, 32'(bus.busy),      32'h1);
        if (mutate) bus.src[1:0] = 2'd2;
        @(negedge clk);
        check({tag, "_stb_rd"},   32'(bus.reg_read),  32'(rd));
        check({tag, "_stb_wr"},   32'(bus.reg_write), 32'(wr));
        check({tag, "_stb_ack"},  32'(bus.ack),       32'h0);
        @(negedge clk);
        check({tag, "_rel_rd"},   32'(bus.reg_read),  32'(rd));
        check({tag, "_rel_wr"},   32'(bus.reg_write), 32'h0);
        check({tag, "_rel_ack"},  32'(bus.ack),       32'h1 << id);
        check({tag, "_rel_err"},  32'(bus.err),       32'h0);
        @(negedge clk);
        check_idle({tag, "_idle"});
    endtask

    initial begin
        rst      = 1'b1;
        bus.req  = '0;
        bus.src  = '0;
        bus.dst  = '0;
        bus3.req = '0;
        bus3.src = '0;
        bus3.dst = '0;

        @(negedge clk);
        check_idle("reset");
        check("reset_busy3", 32'(bus3.busy), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check_idle("noreq");

        // Valid copy 1 -> 3 by requester 0.
        bus.src = {2'd0, 2'd1};
        bus.dst = {2'd0, 2'd3};
        bus.req = 2'b01;
        xfer("cp13", 0, 4'b0010, 4'b1000, 1'b0);
        bus.req = '0;

        // Requester 1 asks src==dst: single reject cycle.
        bus.src = {2'd2, 2'd0};
        bus.dst = {2'd2, 2'd0};
        bus.req = 2'b10;
        @(negedge clk);
        check("rej_rd",   32'(bus.reg_read),  32'h0);
        check("rej_wr",   32'(bus.reg_write), 32'h0);
        check("rej_ack",  32'(bus.ack),       32'h2);
        check("rej_err",  32'(bus.err),       32'h1);
        check("rej_busy", 32'(bus.busy),      32'h1);
        bus.req = '0;
        @(negedge clk);
        check_idle("rej_after");

        // src changes during DRIVE; the latched source must persist.
        bus.src = {2'd0, 2'd1};
        bus.dst = {2'd0, 2'd3};
        bus.req = 2'b01;
        xfer("mut", 0, 4'b0010, 4'b1000, 1'b1);
        bus.req = '0;

        // NREG=3: index 3 is out of range and rejected; 2 -> 0 is valid.
        bus3.src = 2'd0;
        bus3.dst = 2'd3;
        bus3.req = 1'b1;
        @(negedge clk);
        check("oor_ack", 32'(bus3.ack),      32'h1);
        check("oor_err", 32'(bus3.err),      32'h1);
        check("oor_rd",  32'(bus3.reg_read), 32'h0);
        bus3.req = 1'b0;
        @(negedge clk);
        check("oor_busy", 32'(bus3.busy), 32'h0);
        bus3.src = 2'd2;
        bus3.dst = 2'd0;
        bus3.req = 1'b1;
        @(negedge clk);
        check("n3_drv_rd", 32'(bus3.reg_read),  32'h4);
        check("n3_drv_wr", 32'(bus3.reg_write), 32'h0);
        @(negedge clk);
        check("n3_stb_wr", 32'(bus3.reg_write), 32'h1);
        @(negedge clk);
        check("n3_rel_ack", 32'(bus3.ack), 32'h1);
        check("n3_rel_err", 32'(bus3.err), 32'h0);
        bus3.req = 1'b0;
        @(negedge clk);

        // Reset pulsed during STROBE.
        bus.src = {2'd2, 2'd1};
        bus.dst = {2'd0, 2'd3};
        bus.req = 2'b01;
        @(negedge clk);
        check("rs_drv_rd", 32'(bus.reg_read), 32'h2);
        @(negedge clk);
        check("rs_stb_wr", 32'(bus.reg_write), 32'h8);
        #2 rst = 1'b1;
        #1;
        check_idle("rs_async");
        @(negedge clk);
        check_idle("rs_hold");
        bus.req = 2'b11;
        rst     = 1'b0;

        // Both requesters held high: requester 0 first after reset.
        for (int k = 0; k < 4; k++) begin
            int id;
`ifdef REG_BUS_RR_EN
            id = k % 2;
`else
            id = 0;
`endif
            xfer($sformatf("hold%0d", k), id, (id == 0) ? 4'b0010 : 4'b0100,
                 (id == 0) ? 4'b1000 : 4'b0001, 1'b0);
        end
        bus.req = '0;
        @(negedge clk);
        check_idle("end");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/reg_bus_arbiter.md
REG_BUS_ARBITER -- requirements
Module: reg_bus_arbiter

Interface
REQ-001 The block SHALL have parameter NREG, default 4, meaning the number of registers sharing the data bus (2..16).
REQ-002 The block SHALL have parameter NREQ, default 2, meaning the number of transfer requesters (1..8).
REQ-003 Index width IW SHALL be ceil(log2(NREG)), minimum 1.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, reset; reset is asynchronous and active-high.
REQ-006 The block SHALL have port req, input, NREQ, where bit i is requester i asking for a transfer.
REQ-007 The block SHALL have port src, input, NREQ*IW, where slice i is requester i's source register index.
REQ-008 The block SHALL have port dst, input, NREQ*IW, where slice i is requester i's destination register index.
REQ-009 The block SHALL have port ack, input-to-requester output, NREQ, a one-cycle completion pulse to the granted requester.
REQ-010 The block SHALL have port err, output, 1, high together with ack when the completed request was rejected.
REQ-011 The block SHALL have port reg_read, output, NREG, the per-register bus-drive enable.
REQ-012 The block SHALL have port reg_write, output, NREG, the per-register write strobe; the register captures on its rising edge.
REQ-013 The block SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-014 All outputs SHALL be registered (decoded from flops only), with no combinational path from any input to any output.
REQ-015 The FSM SHALL have the states IDLE, DRIVE, STROBE, RELEASE and REJECT.
REQ-016 In IDLE with any req bit high, the block SHALL select one winner, latch its id/src/dst, and move to DRIVE, or to REJECT if src==dst or either index is >= NREG.
REQ-017 In DRIVE, reg_read[src]=1 and reg_write=0 -> STROBE (bus settle cycle).
REQ-018 In STROBE, reg_read[src]=1 and reg_write[dst]=1 -> RELEASE.
REQ-019 In RELEASE, reg_read[src]=1, reg_write=0, ack[id]=1 and err=0 -> IDLE (hold cycle: data stays valid past the write edge).
REQ-020 In REJECT, ack[id]=1 and err=1, with no read or write strobe -> IDLE.
REQ-021 Latency SHALL be: grant in IDLE cycle N, ack in cycle N+3 (valid) or N+1 (rejected); throughput is one transfer per 4 cycles.
REQ-022 reg_read and reg_write SHALL each be at most one-hot; they never select the same index; reg_write is high exactly one cycle per transfer.
REQ-023 req, src and dst SHALL be sampled only in IDLE; changes mid-transfer are ignored and the latched transfer completes.
REQ-024 A requester SHALL drop req on the edge where it sees ack=1; a req still high in the following IDLE SHALL be treated as a new request.
REQ-025 Simultaneous requests SHALL be granted per REQ-031/REQ-032; non-granted requesters wait with no ack.
REQ-026 In IDLE with req==0, outputs SHALL stay at their reset values.

Reset
REQ-027 Asserting rst SHALL immediately force the state to IDLE and clear ack, err, reg_read, reg_write and busy, even mid-transfer.
REQ-028 Asserting rst SHALL immediately reset the round-robin pointer to 0.
REQ-029 A transfer interrupted by reset SHALL be discarded with no ack; the requester re-requests.
REQ-030 After rst deasserts, the first grant SHALL occur no earlier than the first rising clk edge.

Configuration
REQ-031 With REG_BUS_RR_EN defined, arbitration SHALL be round-robin: the search starts at the index after the last granted requester (pointer wraps NREQ-1 -> 0), and the pointer updates on every grant, including rejects.
REQ-032 Without REG_BUS_RR_EN, arbitration SHALL be fixed priority with requester 0 highest, and no pointer flop exists.

Verification
REQ-033 NREG=4, requester 0 asks src=1, dst=3: reg_read=0010 for 3 cycles; reg_write=1000 only in the 2nd; ack[0] in the 3rd; err=0.
REQ-034 Requester 1 asks src=2, dst=2 -> ack[1]=1 and err=1 one cycle after grant; reg_read and reg_write stay 0 throughout.
REQ-035 req=11 held continuously with RR_EN: grants alternate 0,1,0,1; without RR_EN, requester 0 is always served while it re-requests.
REQ-036 rst pulsed during STROBE: all outputs go 0 asynchronously before the next clk edge; no ack is issued; the next grant goes to requester 0.
REQ-037 src changed from 1 to 2 during DRIVE: reg_read stays 0010 for the whole transfer.
